// File: rtl/timer_sched_if.sv
// rtl/timer_sched_if.sv - request/grant bundle between requesters and the shared timer
interface timer_sched_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] dur;
    logic [N-1:0]       gnt;
    logic [N-1:0]       done;
    logic               busy;
    logic [WIDTH-1:0]   count;

    modport master (output req, dur, input gnt, done, busy, count);
    modport slave  (input req, dur, output gnt, done, busy, count);
endinterface

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin scheduler sharing one down-counter among N requesters
module timer_sched #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    timer_sched_if.slave   bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [N-1:0]     done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    sel, cand, nxt;
    logic             found;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        found   = 1'b0;
        sel     = '0;
        cand    = '0;
        nxt     = PW'((int'(idx_q) + 1) % N);
        case (state_q)
            IDLE: begin
                // Search starts at ptr so the last winner goes to the back of the line.
                for (int k = 0; k < N; k++) begin
                    cand = PW'((int'(ptr_q) + k) % N);
                    if (!found && bus.req[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    idx_d      = sel;
                    count_d    = bus.dur[int'(sel)*WIDTH +: WIDTH];
                    if (count_d == '0) begin
                        state_d     = DONE;
                        done_d[sel] = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!bus.req[idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                    ptr_d   = nxt;
                end else if (count_q == WIDTH'(1)) begin
                    state_d       = DONE;
                    count_d       = '0;
                    done_d[idx_q] = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = nxt;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed bench for timer_sched with a deadline-based reference model
module tb_timer_sched;
    localparam int W = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    timer_sched_if #(.WIDTH(W), .N(N)) bus ();
    timer_sched #(.WIDTH(W), .N(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A timer is an owner plus the edge number at which it expires.
    bit     m_active = 1'b0;
    int     m_owner  = 0;
    int     m_ptr    = 0;
    longint cyc      = 0;
    longint m_deadline = 0;
    int     m_glog[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc - 1 == m_deadline || !bus.req[m_owner]) begin
                    m_active = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end else if (bus.req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (bus.req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
                m_active   = 1'b1;
                m_deadline = cyc + longint'(bus.dur[m_owner*W +: W]);
                m_glog.push_back(m_owner);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_gnt", bus.gnt, m_active ? (64'd1 << m_owner) : 64'd0);
            chk("model_done", bus.done, (m_active && cyc == m_deadline) ? (64'd1 << m_owner) : 64'd0);
            chk("model_count", bus.count, (m_active && cyc < m_deadline) ? 64'(m_deadline - cyc) : 64'd0);
            chk("model_busy", bus.busy, m_active);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        bus.req = '0;
        bus.dur = '0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        tick(1);
        reset_n = 1'b1;

        // single request, dur=3
        bus.req = 4'b0001;
        bus.dur = 16'h0003;
        tick(1);
        chk("t1_gnt", bus.gnt, 4'b0001);
        chk("t1_count3", bus.count, 3);
        chk("t1_busy", bus.busy, 1);
        tick(1);
        chk("t1_count2", bus.count, 2);
        tick(1);
        chk("t1_count1", bus.count, 1);
        tick(1);
        chk("t1_done", bus.done, 4'b0001);
        chk("t1_count0", bus.count, 0);
        bus.req = '0;
        tick(1);
        chk("t1_idle_gnt", bus.gnt, 0);
        chk("t1_idle_busy", bus.busy, 0);

        // zero duration
        bus.req = 4'b0010;
        bus.dur = 16'h0000;
        tick(1);
        chk("t2_gnt", bus.gnt, 4'b0010);
        chk("t2_done", bus.done, 4'b0010);
        chk("t2_count", bus.count, 0);
        bus.req = '0;
        tick(1);
        chk("t2_done_off", bus.done, 0);
        chk("t2_gnt_off", bus.gnt, 0);

        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;

        // round robin with all requesters held
        m_glog.delete();
        bus.req = 4'b1111;
        bus.dur = 16'h2222;
        tick(17);
        chk("t3_gnt_edge17", bus.gnt, 4'b0001);
        chk("t3_nglants", m_glog.size(), 5);
        if (m_glog.size() == 5) begin
            chk("t3_order0", m_glog[0], 0);
            chk("t3_order1", m_glog[1], 1);
            chk("t3_order2", m_glog[2], 2);
            chk("t3_order3", m_glog[3], 3);
            chk("t3_order4", m_glog[4], 0);
        end
        bus.req = '0;
        tick(2);

        // abandon
        bus.req = 4'b0100;
        bus.dur = 16'h0A00;
        tick(1);
        chk("t4_gnt", bus.gnt, 4'b0100);
        chk("t4_count10", bus.count, 10);
        tick(4);
        chk("t4_count6", bus.count, 6);
        bus.req = '0;
        tick(1);
        chk("t4_gnt_off", bus.gnt, 0);
        chk("t4_count_off", bus.count, 0);
        chk("t4_no_done", bus.done, 0);
        chk("t4_busy_off", bus.busy, 0);
        chk("t4_ptr", m_ptr, 3);
        bus.req = 4'b1111;
        tick(1);
        chk("t4_next_gnt", bus.gnt, 4'b1000);
        bus.req = '0;
        tick(2);

        // async reset mid-RUN
        bus.req = 4'b0001;
        bus.dur = 16'h0008;
        tick(4);
        chk("t5_count5", bus.count, 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_gnt", bus.gnt, 0);
        chk("t5_rst_done", bus.done, 0);
        chk("t5_rst_count", bus.count, 0);
        chk("t5_rst_busy", bus.busy, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("t5_regnt", bus.gnt, 4'b0001);
        chk("t5_recount", bus.count, 8);
        bus.req = '0;
        tick(2);

        // all-ones duration
        bus.req = 4'b0010;
        bus.dur = 16'h00F0;
        tick(1);
        chk("t6_gnt", bus.gnt, 4'b0010);
        chk("t6_count15", bus.count, 15);
        tick(14);
        chk("t6_count1", bus.count, 1);
        chk("t6_not_done", bus.done, 0);
        tick(1);
        chk("t6_done", bus.done, 4'b0010);
        chk("t6_count0", bus.count, 0);
        bus.req = '0;
        tick(1);
        chk("t6_idle_gnt", bus.gnt, 0);
        chk("t6_idle_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
